// File: rtl/fine_delay_interp_pkg.sv
// Shared parameters and state encoding for the fine-delay interpolator.
// Holds the default widths and the IDLE/RUN encoding used by every file of the block.
package fine_delay_interp_pkg;

  localparam int FDI_INPUT_WD  = 14;
  localparam int FDI_FRAC_WD   = 4;
  localparam int FDI_ADDR_WD   = 12;
  localparam int FDI_FD_OUT_WD = 31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fdi_state_e;

  // Full-precision product width: sample times a weight of up to 2^FRAC_WD, plus sign.
  function automatic int fdi_prod_wd(input int input_wd, input int frac_wd);
    return input_wd + frac_wd + 2;
  endfunction

endpackage

// File: rtl/fine_delay_interp_lut.sv
// Fine-delay phase table fd_phase_lut: simple dual-port RAM with one write port
// and one synchronous read port (1-cycle read latency).
module fd_phase_lut
  import fine_delay_interp_pkg::*;
#(
  parameter int ADDR_WD = FDI_ADDR_WD,
  parameter int DATA_WD = FDI_FRAC_WD
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_WD-1:0] wr_addr,
  input  logic [DATA_WD-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_WD-1:0] rd_addr,
  output logic [DATA_WD-1:0] rd_data
);

  logic [DATA_WD-1:0] mem_q [2**ADDR_WD];

  // NOTE: the storage array has no reset so it maps onto block RAM; its contents
  // survive rst_n, and only the surrounding control logic is reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/fine_delay_interp.sv
// Fine-delay interpolator: y = x*(2^F - f) + x_prev*f with a per-sample phase
// read from a programmable table. Optional macro FD_BYPASS_EN adds fd_bypass.
module fine_delay_interp
  import fine_delay_interp_pkg::*;
#(
  parameter int INPUT_WD  = FDI_INPUT_WD,
  parameter int FRAC_WD   = FDI_FRAC_WD,
  parameter int ADDR_WD   = FDI_ADDR_WD,
  parameter int FD_OUT_WD = FDI_FD_OUT_WD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tx_en,
  input  logic                        start,
  input  logic signed [INPUT_WD-1:0]  fine_din,
  input  logic                        fine_din_valid,
  input  logic [ADDR_WD-1:0]          lut_addr,
  input  logic                        lut_wr_en,
  input  logic [FRAC_WD-1:0]          lut_wdata,
`ifdef FD_BYPASS_EN
  input  logic                        fd_bypass,
`endif
  output logic signed [FD_OUT_WD-1:0] fine_dout,
  output logic                        fine_dout_valid
);

  localparam int PROD_WD = fdi_prod_wd(INPUT_WD, FRAC_WD);

  fdi_state_e                 state_q;
  logic [ADDR_WD-1:0]         rd_ptr_q;
  logic [ADDR_WD-1:0]         rd_ptr_d;
  logic signed [INPUT_WD-1:0] xprev_q;

  logic                       s1_valid_q;
  logic signed [INPUT_WD-1:0] s1_din_q;
  logic signed [INPUT_WD-1:0] s1_xprev_q;

  logic                       s2_valid_q;
  logic signed [PROD_WD-1:0]  prod_cur_d;
  logic signed [PROD_WD-1:0]  prod_prev_d;
  logic signed [PROD_WD-1:0]  prod_cur_q;
  logic signed [PROD_WD-1:0]  prod_prev_q;

  logic                        out_valid_q;
  logic signed [FD_OUT_WD-1:0] sum_d;
  logic signed [FD_OUT_WD-1:0] dout_q;

  logic               in_run;
  logic               go_run;
  logic               stop_run;
  logic               accept;
  logic               lut_we;
  logic [FRAC_WD-1:0] lut_rdata;
  logic [FRAC_WD-1:0] phase;
  logic [FRAC_WD:0]   weight_cur;

  assign in_run   = (state_q == ST_RUN);
  assign go_run   = !in_run && start && !tx_en;
  assign stop_run = in_run && (!start || tx_en);
  // A sample on the exit cycle is dropped together with everything in flight.
  assign accept   = in_run && fine_din_valid && !stop_run;
  assign lut_we   = !in_run && lut_wr_en;

  fd_phase_lut #(
    .ADDR_WD (ADDR_WD),
    .DATA_WD (FRAC_WD)
  ) u_lut (
    .clk     (clk),
    .wr_en   (lut_we),
    .wr_addr (lut_addr),
    .wr_data (lut_wdata),
    .rd_en   (accept),
    .rd_addr (rd_ptr_q),
    .rd_data (lut_rdata)
  );

`ifdef FD_BYPASS_EN
  logic bypass_q;
  assign phase = bypass_q ? '0 : lut_rdata;
`else
  assign phase = lut_rdata;
`endif

  // NOTE: every signal written here gets a value on every path, so no latch is
  // inferred; keep a default first if a branchy assignment is ever added.
  always_comb begin
    rd_ptr_d    = (rd_ptr_q == '1) ? rd_ptr_q : rd_ptr_q + ADDR_WD'(1);
    weight_cur  = {1'b1, {FRAC_WD{1'b0}}} - {1'b0, phase};
    prod_cur_d  = PROD_WD'(s1_din_q) * PROD_WD'($signed({1'b0, weight_cur}));
    prod_prev_d = PROD_WD'(s1_xprev_q) * PROD_WD'($signed({1'b0, phase}));
    sum_d       = FD_OUT_WD'(prod_cur_q) + FD_OUT_WD'(prod_prev_q);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      xprev_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_din_q    <= '0;
      s1_xprev_q  <= '0;
      s2_valid_q  <= 1'b0;
      prod_cur_q  <= '0;
      prod_prev_q <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
`ifdef FD_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_run) begin
            state_q  <= ST_RUN;
            rd_ptr_q <= '0;
            xprev_q  <= '0;
`ifdef FD_BYPASS_EN
            bypass_q <= fd_bypass;
`endif
          end
        end
        ST_RUN: begin
          if (stop_run) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (accept) begin
        rd_ptr_q   <= rd_ptr_d;
        xprev_q    <= fine_din;
        s1_din_q   <= fine_din;
        s1_xprev_q <= xprev_q;
      end
      s1_valid_q <= accept;

      s2_valid_q  <= s1_valid_q && !stop_run;
      prod_cur_q  <= prod_cur_d;
      prod_prev_q <= prod_prev_d;

      out_valid_q <= s2_valid_q && !stop_run;
      dout_q      <= (s2_valid_q && !stop_run) ? sum_d : '0;
    end
  end

  assign fine_dout       = dout_q;
  assign fine_dout_valid = out_valid_q;

endmodule

// File: tb/tb_fine_delay_interp.sv
// Self-checking bench for fine_delay_interp: directed scenarios plus random
// traffic compared against a cycle-indexed behavioural model.
module tb_fine_delay_interp;

  localparam int INPUT_WD  = 14;
  localparam int FRAC_WD   = 4;
  localparam int ADDR_WD   = 2;
  localparam int FD_OUT_WD = 31;
  localparam int DEPTH     = 1 << ADDR_WD;
  localparam int PHASES    = 1 << FRAC_WD;
  localparam int LATENCY   = 3;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        tx_en = 1'b0;
  logic                        start = 1'b0;
  logic signed [INPUT_WD-1:0]  fine_din = '0;
  logic                        fine_din_valid = 1'b0;
  logic [ADDR_WD-1:0]          lut_addr = '0;
  logic                        lut_wr_en = 1'b0;
  logic [FRAC_WD-1:0]          lut_wdata = '0;
  logic signed [FD_OUT_WD-1:0] fine_dout;
  logic                        fine_dout_valid;
`ifdef FD_BYPASS_EN
  logic                        fd_bypass = 1'b0;
`endif

  always #5 clk = ~clk;

  fine_delay_interp #(
    .INPUT_WD  (INPUT_WD),
    .FRAC_WD   (FRAC_WD),
    .ADDR_WD   (ADDR_WD),
    .FD_OUT_WD (FD_OUT_WD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tx_en           (tx_en),
    .start           (start),
    .fine_din        (fine_din),
    .fine_din_valid  (fine_din_valid),
    .lut_addr        (lut_addr),
    .lut_wr_en       (lut_wr_en),
    .lut_wdata       (lut_wdata),
`ifdef FD_BYPASS_EN
    .fd_bypass       (fd_bypass),
`endif
    .fine_dout       (fine_dout),
    .fine_dout_valid (fine_dout_valid)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: table contents, run flag, phase index, previous sample,
  // and the expected output for each upcoming cycle (ring indexed by cycle).
  int     lut_m [DEPTH];
  bit     m_run = 1'b0;
  int     m_ptr = 0;
  int     m_xprev = 0;
  bit     exp_v [8];
  longint exp_d [8];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_slot(input string tag);
    int slot;
    slot = cyc % 8;
    check({tag, "_valid"}, longint'(fine_dout_valid), longint'(exp_v[slot]));
    check({tag, "_dout"}, longint'(fine_dout), exp_v[slot] ? exp_d[slot] : 64'sd0);
    exp_v[slot] = 1'b0;
    exp_d[slot] = 0;
  endtask

  // One clock cycle: check what the DUT shows now, drive new inputs, and
  // advance the model to what those inputs mean at the coming edge.
  task automatic step(input bit v, input int d, input bit st, input bit tx,
                      input bit we, input int wa, input int wd);
    int     f;
    longint y;
    @(negedge clk);
    check_slot("out");
    fine_din_valid = v;
    fine_din       = INPUT_WD'(d);
    start          = st;
    tx_en          = tx;
    lut_wr_en      = we;
    lut_addr       = ADDR_WD'(wa);
    lut_wdata      = FRAC_WD'(wd);
    if (!m_run) begin
      if (we) lut_m[wa] = wd;
      if (st && !tx) begin
        m_run   = 1'b1;
        m_ptr   = 0;
        m_xprev = 0;
      end
    end else if (!st || tx) begin
      m_run = 1'b0;
      for (int k = 1; k <= LATENCY; k++) exp_v[(cyc + k) % 8] = 1'b0;
    end else if (v) begin
      f = lut_m[m_ptr];
      y = longint'(d) * (PHASES - f) + longint'(m_xprev) * f;
      exp_v[(cyc + LATENCY) % 8] = 1'b1;
      exp_d[(cyc + LATENCY) % 8] = y;
      m_xprev = d;
      if (m_ptr < DEPTH - 1) m_ptr++;
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic hold_run(input int n);
    repeat (n) step(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic sample(input int d);
    step(1'b1, d, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic write_lut(input int a, input int v);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1, a, v);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    check_slot("pre_rst");
    rst_n          = 1'b0;
    fine_din_valid = 1'b0;
    start          = 1'b0;
    tx_en          = 1'b0;
    lut_wr_en      = 1'b0;
    #1;
    check("rst_async_valid", longint'(fine_dout_valid), 0);
    check("rst_async_dout", longint'(fine_dout), 0);
    m_run   = 1'b0;
    m_ptr   = 0;
    m_xprev = 0;
    for (int k = 0; k < 8; k++) exp_v[k] = 1'b0;
    cyc++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      exp_v[k] = 1'b0;
      exp_d[k] = 0;
    end
    for (int k = 0; k < DEPTH; k++) lut_m[k] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", longint'(fine_dout_valid), 0);
    check("reset_dout", longint'(fine_dout), 0);
    #1 rst_n = 1'b1;
    idle_cycles(2);

    // All phases zero: output is the sample scaled by 2^FRAC_WD.
    for (int a = 0; a < DEPTH; a++) write_lut(a, 0);
    hold_run(1);
    sample(100);
    sample(-50);
    hold_run(4);
    idle_cycles(1);

    // Half-phase blend, first sample blends against a cleared x_prev.
    write_lut(0, 8);
    write_lut(1, 8);
    hold_run(1);
    sample(100);
    sample(200);
    hold_run(4);
    idle_cycles(1);

    // Extreme sample values with f=0 and f=15.
    write_lut(0, 0);
    write_lut(1, 0);
    write_lut(2, 15);
    hold_run(1);
    sample(-8192);
    sample(8191);
    sample(-8192);
    hold_run(4);
    idle_cycles(1);

    // tx_en abort discards in-flight samples; restart begins at entry 0.
    write_lut(0, 3);
    write_lut(1, 5);
    write_lut(2, 7);
    write_lut(3, 9);
    hold_run(1);
    sample(1000);
    sample(-2000);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 0);
    idle_cycles(4);
    hold_run(1);
    sample(300);
    sample(-400);
    hold_run(4);
    idle_cycles(1);

    // Table write attempted during RUN is ignored.
    hold_run(1);
    step(1'b1, 500, 1'b1, 1'b0, 1'b1, 0, 15);
    hold_run(3);
    idle_cycles(1);
    hold_run(1);
    sample(700);
    hold_run(4);
    idle_cycles(1);

    // Gaps in valid, pointer saturation, then reset in the middle of a run.
    hold_run(1);
    sample(-300);
    hold_run(1);
    sample(-189);
    sample(-78);
    sample(33);
    hold_run(2);
    sample(144);
    sample(255);
    pulse_reset();
    step(1'b1, 1234, 1'b0, 1'b0, 1'b0, 0, 0);
    idle_cycles(4);

    // Table contents survive reset.
    hold_run(1);
    sample(50);
    sample(-60);
    hold_run(4);
    idle_cycles(1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)),
           int'($urandom_range(0, 16383)) - 8192,
           ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, DEPTH - 1)),
           int'($urandom_range(0, PHASES - 1)));
    end
    idle_cycles(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fine_delay_interp.md
FINE_DELAY_INTERP -- requirements
Module: fine_delay_interp

Interface
REQ-001 Parameter INPUT_WD, default 14, signed width of the coarse-delayed sample.
REQ-002 Parameter FRAC_WD, default 4, width of the fine-delay phase (2^FRAC_WD phases per sample).
REQ-003 Parameter ADDR_WD, default 12, width of the fine-delay LUT address (LUT depth 2^ADDR_WD).
REQ-004 Parameter FD_OUT_WD, default 31, signed output width.
REQ-005 Ports: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-006 Ports: tx_en input 1 transmit active; start input 1 receive window active.
REQ-007 Ports: fine_din input INPUT_WD signed coarse-delayed sample; fine_din_valid input 1 sample qualifier.
REQ-008 Ports: lut_addr input ADDR_WD LUT write address; lut_wr_en input 1 LUT write strobe; lut_wdata input FRAC_WD phase value.
REQ-009 Ports: fine_dout output FD_OUT_WD signed interpolated sample; fine_dout_valid output 1 qualifier.

Function
REQ-010 The block SHALL implement two states, IDLE (reset state) and RUN.
REQ-011 IDLE->RUN SHALL occur on a cycle with start=1 and tx_en=0; RUN->IDLE SHALL occur on any cycle with start=0 or tx_en=1.
REQ-012 On entering RUN, the read pointer and the previous-sample register x_prev SHALL be cleared to 0.
REQ-013 In RUN, each fine_din_valid=1 cycle SHALL read phase f=LUT[rd_ptr], then increment rd_ptr.
REQ-014 rd_ptr SHALL saturate at 2^ADDR_WD-1 (no wrap); further samples reuse the last entry.
REQ-015 Output: y = fine_din*(2^FRAC_WD - f) + x_prev*f, full precision, sign-extended to FD_OUT_WD.
REQ-016 x_prev SHALL update to fine_din only on accepted samples (valid=1 in RUN).
REQ-017 Latency SHALL be exactly 3 cycles from accepted sample to fine_dout_valid=1 (LUT read, multiply, sum).
REQ-018 Samples with fine_din_valid=0, or arriving in IDLE, SHALL produce no output and SHALL NOT advance rd_ptr.
REQ-019 On RUN->IDLE, all in-flight pipeline valids SHALL be cleared; from the next cycle, fine_dout=0 and fine_dout_valid=0.
REQ-020 LUT writes (lut_wr_en=1) SHALL take effect only in IDLE and SHALL be ignored in RUN.
REQ-021 When fine_dout_valid=0, fine_dout SHALL be driven to 0.

Reset
REQ-022 rst_n=0 SHALL asynchronously force IDLE, rd_ptr=0, x_prev=0, all pipeline registers and valids=0, fine_dout=0, fine_dout_valid=0.
REQ-023 LUT contents SHALL NOT be reset; reset mid-RUN SHALL discard in-flight samples.

Configuration
REQ-024 Macro FD_BYPASS_EN: when defined, a 1-bit input fd_bypass SHALL exist, be sampled on IDLE->RUN, and, if 1, force f=0 for the whole RUN (y = fine_din<<FRAC_WD, same 3-cycle latency, rd_ptr still advances).
REQ-025 Without FD_BYPASS_EN, the fd_bypass port SHALL be absent and the block SHALL always interpolate.

Structure
REQ-026 INPUT_WD, FRAC_WD, ADDR_WD, FD_OUT_WD defaults and the IDLE/RUN state encoding SHALL reside in the shared parameter header.
REQ-027 The LUT SHALL be a separate sub-module fd_phase_lut (simple dual-port RAM, 1 write port, 1 synchronous read port, 1-cycle read latency).

Verification
REQ-028 LUT all f=0, RUN, samples 100,-50 -> outputs 1600,-800, valid 3 cycles after each input.
REQ-029 LUT[0]=8, LUT[1]=8, samples 100,200 -> outputs 800 (x_prev=0), 2400.
REQ-030 f=0, sample -8192 -> -131072; f=15, x_prev=8191, sample -8192 -> 114673.
REQ-031 tx_en=1 asserted one cycle after two accepted samples -> no further valid outputs, fine_dout=0 next cycle; re-start -> rd_ptr restarts at 0.
REQ-032 lut_wr_en=1 during RUN to address 0 with value 15 -> LUT[0] unchanged on readback through the next RUN.
REQ-033 ADDR_WD=2, six accepted samples -> samples 4..6 use LUT[3]; rst_n pulse mid-RUN -> outputs 0 immediately and state IDLE.
